// File: rtl/sipo_receiver.sv
// Serial-in parallel-out receiver: assembles LSB-first words into a holding register.
// Optional even-parity bit per word when SIPO_PARITY_EN is defined (adds parity_err port).
module sipo_receiver #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             shift_en,
   input  logic             data_ack,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy,
`ifdef SIPO_PARITY_EN
   output logic             parity_err,
`endif
   output logic             overrun
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
   typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
   typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  sreg_q, sreg_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;
`ifdef SIPO_PARITY_EN
   logic              perr_q, perr_d;
   logic              done_perr;
`endif

   logic              word_done;
   logic [WIDTH-1:0]  done_word;
   logic [WIDTH-1:0]  word_w;

   // Partial word with the current serial bit placed at position cnt_q.
   always_comb begin
      word_w = sreg_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (cnt_q == CntW'(i)) begin
            word_w[i] = serial_in;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sreg_d    = sreg_q;
      word_done = 1'b0;
      done_word = sreg_q;
`ifdef SIPO_PARITY_EN
      done_perr = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (shift_en) begin
               sreg_d  = word_w;
               cnt_d   = CntW'(1);
               state_d = StShift;
            end
         end
         StShift: begin
            if (shift_en) begin
               if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                  sreg_d  = word_w;
                  cnt_d   = CntW'(WIDTH);
                  state_d = StParity;
`else
                  word_done = 1'b1;
                  done_word = word_w;
                  sreg_d    = '0;
                  cnt_d     = '0;
                  state_d   = StIdle;
`endif
               end else begin
                  sreg_d = word_w;
                  cnt_d  = cnt_q + CntW'(1);
               end
            end
         end
`ifdef SIPO_PARITY_EN
         StParity: begin
            if (shift_en) begin
               word_done = 1'b1;
               done_word = sreg_q;
               done_perr = (^sreg_q) ^ serial_in;
               sreg_d    = '0;
               cnt_d     = '0;
               state_d   = StIdle;
            end
         end
`endif
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            sreg_d  = '0;
         end
      endcase
   end

   // Holding register: a completed word is dropped only if the old one is still unclaimed.
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
`ifdef SIPO_PARITY_EN
      perr_d  = perr_q;
`endif
      if (word_done) begin
         if (!valid_q || data_ack) begin
            dout_d  = done_word;
            valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
            perr_d  = done_perr;
`endif
         end else begin
            ovr_d = 1'b1;
         end
      end else if (data_ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sreg_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
`ifdef SIPO_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign busy       = (state_q != StIdle);
   assign overrun    = ovr_q;
`ifdef SIPO_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, word length in data bits (2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port serial_in  input  1  serial data bit, LSB first, as sent by the team's parallel-in serial-out shifter.
REQ-005 SHALL have port shift_en  input  1  high = serial_in carries a valid bit this cycle; same sense as the transmitter's SHIFT_LOAD.
REQ-006 SHALL have port data_ack  input  1  consumer accepts the held word.
REQ-007 SHALL have port data_out  output  WIDTH  holding register, last completed word.
REQ-008 SHALL have port data_valid  output  1  holding register full.
REQ-009 SHALL have port busy  output  1  partial word in progress (state SHIFT).
REQ-010 SHALL have port overrun  output  1  sticky, a completed word was dropped.
REQ-011 SHALL have port parity_err  output  1  parity result of the held word; present only with SIPO_PARITY_EN.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and, with SIPO_PARITY_EN only, PARITY.
REQ-013 SHALL sample serial_in on every rising clk edge where shift_en=1 and ignore it when shift_en=0.
REQ-014 SHALL shift sampled bits so that the first bit lands in bit 0 and bit k lands in bit k.
REQ-015 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits: 0 in IDLE, incremented per sampled bit, never exceeding WIDTH.
REQ-016 SHALL transition IDLE->SHIFT on the first sampled bit, with count=1 and busy=1 from the next cycle.
REQ-017 SHALL, when shift_en=0 mid-word, hold state, count and partial data indefinitely (no timeout).
REQ-018 SHALL complete a word on the edge sampling bit WIDTH-1 (or the parity bit with SIPO_PARITY_EN), then return to IDLE with count=0.
REQ-019 SHALL, at completion with data_valid=0 or data_ack=1, load data_out and set data_valid=1 at that same edge (visible the cycle after the last bit).
REQ-020 SHALL, at completion with data_valid=1 and data_ack=0, drop the new word, keep data_out unchanged, and set overrun=1.
REQ-021 SHALL clear data_valid on an edge with data_ack=1 and no simultaneous completion; data_ack with data_valid=0 has no effect.
REQ-022 SHALL accept a new word back-to-back: a first bit sampled on the completion edge's following cycle starts the next word with no gap cycle.
REQ-023 SHALL keep overrun set until reset.

Reset
REQ-024 SHALL, on reset assertion, immediately force state=IDLE, count=0, shift register=0, data_out=0, data_valid=0, busy=0, overrun=0, parity_err=0, regardless of clk.
REQ-025 SHALL discard any partial word on reset mid-operation; the first sampled bit after release is bit 0.

Configuration
REQ-026 SHALL support macro SIPO_PARITY_EN: when defined, each word is WIDTH data bits followed by one even-parity bit sampled in state PARITY, parity_err=XOR(data,parity bit) is loaded together with data_out, and the parity_err port exists.
REQ-027 SHALL, without SIPO_PARITY_EN, omit the PARITY state and the parity_err port and complete words after exactly WIDTH bits.

Verification (WIDTH=4)
REQ-028 SHALL verify: shift_en=1 with serial bits 1,0,1,1 -> data_out=4'b1101, data_valid=1 the cycle after the 4th edge, busy=0.
REQ-029 SHALL verify: bits 1,0 then shift_en=0 for 5 cycles then 0,1 -> data_out=4'b1001, busy=1 throughout the pause.
REQ-030 SHALL verify: two words 4'b1101 and 4'b0110 with no data_ack -> data_out stays 4'b1101, overrun=1.
REQ-031 SHALL verify: data_ack=1 on the completion edge of 4'b0110 while 4'b1101 is held -> data_out=4'b0110, data_valid stays 1, overrun=0.
REQ-032 SHALL verify: reset pulsed after 2 bits, then bits 0,0,1,0 -> data_out=4'b0100, all outputs 0 during reset.
REQ-033 SHALL verify, with SIPO_PARITY_EN: bits 1,0,1,1 followed by parity 0 -> parity_err=1; with parity 1 -> parity_err=0.
